// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : display_scan_ctrl
// Brief    : Self-timed multi-digit 7-segment scan controller with frame-
//            synchronous double-buffered data, ghost blanking, enable, blink.
// Revision : 1.0  initial release
// ============================================================================
module display_scan_ctrl #(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 500,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*DIGITS-1:0]       hexs,
    input  logic [DIGITS-1:0]         points,
    input  logic [DIGITS-1:0]         digit_en,
    input  logic [DIGITS-1:0]         blink,
    input  logic                      freeze,
    output logic [3:0]                hex,
    output logic                      p,
    output logic                      le,
    output logic [DIGITS-1:0]         an,
    output logic [$clog2(DIGITS)-1:0] scan,
    output logic                      frame_start
);

    localparam int SW = $clog2(DIGITS);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DW-1:0] DIV_LAST  = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] BLANK_END = DW'(BLANK_CYC);
    localparam logic [SW-1:0] SCAN_LAST = SW'(DIGITS - 1);
    localparam logic [FW-1:0] FRM_LAST  = FW'(BLINK_FRAMES - 1);

    logic [DW-1:0]         div_q,      div_d;
    logic [SW-1:0]         scan_q,     scan_d;
    logic [FW-1:0]         frm_q,      frm_d;
    logic                  ph_q,       ph_d;
    logic                  started_q;
    logic [4*DIGITS-1:0]   sh_hexs_q,  sh_hexs_d;
    logic [DIGITS-1:0]     sh_pts_q,   sh_pts_d;
    logic [DIGITS-1:0]     sh_en_q,    sh_en_d;
    logic [DIGITS-1:0]     sh_blk_q,   sh_blk_d;

    logic slot_end;
    logic frame_end;
    logic lit;

    always_comb begin
        slot_end  = (div_q == DIV_LAST);
        frame_end = slot_end && (scan_q == SCAN_LAST);

        div_d     = slot_end ? '0 : div_q + 1'b1;
        scan_d    = scan_q;
        frm_d     = frm_q;
        ph_d      = ph_q;
        sh_hexs_d = sh_hexs_q;
        sh_pts_d  = sh_pts_q;
        sh_en_d   = sh_en_q;
        sh_blk_d  = sh_blk_q;

        if (slot_end) begin
            scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + 1'b1;
        end

        // Shadow data only moves at the frame wrap so a frame never mixes old and new digits.
        if (frame_end) begin
            if (frm_q == FRM_LAST) begin
                frm_d = '0;
                ph_d  = ~ph_q;
            end else begin
                frm_d = frm_q + 1'b1;
            end
            if (!freeze) begin
                sh_hexs_d = hexs;
                sh_pts_d  = points;
                sh_en_d   = digit_en;
                sh_blk_d  = blink;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            scan_q    <= '0;
            frm_q     <= '0;
            ph_q      <= 1'b0;
            started_q <= 1'b0;
            sh_hexs_q <= '0;
            sh_pts_q  <= '0;
            sh_en_q   <= '0;
            sh_blk_q  <= '0;
        end else begin
            div_q     <= div_d;
            scan_q    <= scan_d;
            frm_q     <= frm_d;
            ph_q      <= ph_d;
            started_q <= 1'b1;
            sh_hexs_q <= sh_hexs_d;
            sh_pts_q  <= sh_pts_d;
            sh_en_q   <= sh_en_d;
            sh_blk_q  <= sh_blk_d;
        end
    end

    // The first BLANK_CYC cycles of each slot keep all anodes dark to hide ghosting.
    always_comb begin
        lit         = (div_q >= BLANK_END) && sh_en_q[scan_q] && !(sh_blk_q[scan_q] && ph_q);
        an          = lit ? ~(DIGITS'(1) << scan_q) : '1;
        le          = lit;
        hex         = sh_hexs_q[{scan_q, 2'b00} +: 4];
        p           = sh_pts_q[scan_q] & lit;
        scan        = scan_q;
        frame_start = started_q && (scan_q == '0) && (div_q == '0);
    end

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_scan_ctrl
// Brief    : Directed self-checking bench for display_scan_ctrl (4 digits).
// Revision : 1.0  initial release
// ============================================================================
module tb_display_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] hexs = 16'h0;
    logic [3:0]  points = 4'h0;
    logic [3:0]  digit_en = 4'h0;
    logic [3:0]  blink = 4'h0;
    logic        freeze = 1'b0;
    logic [3:0]  hex;
    logic        p;
    logic        le;
    logic [3:0]  an;
    logic [1:0]  scan;
    logic        frame_start;

    display_scan_ctrl #(
        .DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1), .BLINK_FRAMES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hexs(hexs), .points(points),
        .digit_en(digit_en), .blink(blink), .freeze(freeze),
        .hex(hex), .p(p), .le(le), .an(an), .scan(scan),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cnt    = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: n = clock edges since reset release; every quantity follows from it.
    int          n = 0;
    logic [15:0] m_hexs = 16'h0;
    logic [3:0]  m_pts = 4'h0, m_en = 4'h0, m_blk = 4'h0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                n = 0; m_hexs = '0; m_pts = '0; m_en = '0; m_blk = '0;
            end else begin
                if ((n % 16) == 15 && !freeze) begin
                    m_hexs = hexs; m_pts = points; m_en = digit_en; m_blk = blink;
                end
                n++;
            end
        end
    end

    initial begin
        int  div, slot, ph;
        bit  lit;
        forever begin
            @(negedge clk);
            #3;
            if (chk_on) begin
                div  = n % 4;
                slot = (n / 4) % 4;
                ph   = ((n / 16) / 2) % 2;
                lit  = (div >= 1) && m_en[slot] && !(m_blk[slot] && ph == 1);
                check("m_an",    32'(an),          lit ? 32'(~(4'b0001 << slot) & 4'hF) : 32'hF);
                check("m_le",    32'(le),          32'(lit));
                check("m_hex",   32'(hex),         32'(m_hexs[slot*4 +: 4]));
                check("m_p",     32'(p),           32'(m_pts[slot] & lit));
                check("m_scan",  32'(scan),        32'(slot));
                check("m_fs",    32'(frame_start), 32'((n % 16 == 0) && n > 0));
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
        cnt++;
    endtask

    task automatic goto(input int t);
        while (cnt < t) step();
    endtask

    task automatic scen1_pins();
        check("s1_an0",   32'(an), 32'hF);
        check("s1_hex0",  32'(hex), 32'h0);
        check("s1_fs0",   32'(frame_start), 32'h0);
        goto(5);
        check("s1_an5",   32'(an), 32'hF);
        check("s1_scan5", 32'(scan), 32'h1);
        goto(16);
        check("s1_fs16",  32'(frame_start), 32'h1);
        check("s1_hex16", 32'(hex), 32'h1);
        check("s1_an16",  32'(an), 32'hF);
        goto(17);
        check("s1_an17",  32'(an), 32'hE);
        check("s1_le17",  32'(le), 32'h1);
        check("s1_fs17",  32'(frame_start), 32'h0);
        goto(21);
        check("s1_an21",  32'(an), 32'hD);
        check("s1_hex21", 32'(hex), 32'h2);
        check("s1_p21",   32'(p), 32'h1);
        goto(29);
        check("s1_an29",  32'(an), 32'h7);
        check("s1_hex29", 32'(hex), 32'h4);
        goto(32);
        check("s1_fs32",  32'(frame_start), 32'h1);
    endtask

    task automatic load_s1_inputs();
        hexs = 16'h4321; points = 4'b0010; digit_en = 4'hF; blink = 4'h0; freeze = 1'b0;
    endtask

    initial begin
        load_s1_inputs();
        repeat (3) @(negedge clk);
        #1;
        chk_on = 1'b1;
        check("rst_an",  32'(an), 32'hF);
        check("rst_le",  32'(le), 32'h0);
        check("rst_p",   32'(p), 32'h0);
        rst_n = 1'b1;
        cnt   = 0;
        scen1_pins();

        goto(37);  hexs = 16'hABCD;
        goto(45);  check("s2_hex45", 32'(hex), 32'h4);
        goto(48);  check("s2_hex48", 32'(hex), 32'hD);
        goto(50);  digit_en = 4'b0101; points = 4'hF;
        goto(53);  check("s2_hex53", 32'(hex), 32'hC);
                   check("s2_an53",  32'(an), 32'hD);
        goto(65);  check("s3_an65",  32'(an), 32'hE);
                   check("s3_p65",   32'(p), 32'h1);
        goto(69);  check("s3_an69",  32'(an), 32'hF);
                   check("s3_le69",  32'(le), 32'h0);
                   check("s3_p69",   32'(p), 32'h0);
        goto(77);  check("s3_an77",  32'(an), 32'hF);
        goto(82);  blink = 4'b0001; digit_en = 4'hF;
        goto(97);  check("s4_an97",  32'(an), 32'hF);
                   check("s4_le97",  32'(le), 32'h0);
        goto(101); check("s4_an101", 32'(an), 32'hD);
        goto(113); check("s4_an113", 32'(an), 32'hF);
        goto(129); check("s4_an129", 32'(an), 32'hE);
        goto(145); check("s4_an145", 32'(an), 32'hE);
        goto(161); check("s4_an161", 32'(an), 32'hF);
        goto(170); blink = 4'h0;
        goto(180); freeze = 1'b1; hexs = 16'h5678;
        goto(193); check("s5_hex193", 32'(hex), 32'hD);
                   check("s5_an193",  32'(an), 32'hE);
        goto(225); check("s5_hex225", 32'(hex), 32'hD);
        goto(230); freeze = 1'b0;
        goto(240); check("s5_hex240", 32'(hex), 32'h8);
        goto(244); check("s5_hex244", 32'(hex), 32'h7);
        goto(245); freeze = 1'b1; hexs = 16'h1111;
        goto(252); check("s5_hex252", 32'(hex), 32'h5);
        goto(255); freeze = 1'b0;
        goto(256); check("s5_hex256", 32'(hex), 32'h1);
                   check("s5_fs256",  32'(frame_start), 32'h1);
        goto(266); check("s6_an_pre", 32'(an), 32'hB);
        rst_n = 1'b0;
        #1;
        check("s6_an_rst",   32'(an), 32'hF);
        check("s6_scan_rst", 32'(scan), 32'h0);
        check("s6_hex_rst",  32'(hex), 32'h0);
        load_s1_inputs();
        repeat (3) step();
        rst_n = 1'b1;
        cnt   = 0;
        scen1_pins();
        goto(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
